add_sub_pipe: RTL
=================

# add_sub_pipe

Parametrised, pipelined ripple-carry adder/subtractor. Replaces the fixed 4-bit combinational ripple adder for wide datapaths. The operand is split into CHUNK-bit slices, and one slice is resolved per pipeline stage, with the carry registered between stages. This gives one operation per cycle at a clock rate set by a CHUNK-bit carry chain rather than a WIDTH-bit one. Adds subtract mode, signed-overflow flag and valid/ready flow control.

## Interface
- WIDTH, 16: operand and sum width in bits; must be a multiple of CHUNK, otherwise an elaboration error.
- CHUNK, 4: bits resolved per stage; STAGES = WIDTH/CHUNK is the latency in cycles.
- clk  in  1  rising-edge clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry in.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of the MSB; in subtract mode, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- Accept: an operand set is accepted when in_valid && in_ready.
- Effective operand: b_eff = sub ? ~b : b.
- Result: {c_out, sum} = a + b_eff + c_in, computed modulo 2^(WIDTH+1). So sub=1, c_in=1 gives a−b; sub=1, c_in=0 gives a−b−1, which supports chained borrow.
- ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
- Stage k (0..STAGES−1) adds slice k of a and b_eff with the carry registered by stage k−1. Stage 0 uses the accepted c_in.
- Skew registers carry the not-yet-used upper slices, plus the MSB of a and b_eff for ovf, forward.
- Deskew registers carry the already-computed lower sum slices forward.
- Each stage has a valid bit. Bubbles propagate as invalid stages. Data in invalid stages is don't-care, but the output registers hold their last value.
- Flow control is whole-pipeline stall:
  - in_ready = !(out_valid && !out_ready).
  - When in_ready = 0, every stage register, valid bits included, holds.
- No reordering, no drops, no duplication.

## Timing
- Reset (asynchronous assert, synchronous release by the system):
  - all stage valid bits clear;
  - out_valid = 0, sum = 0, c_out = 0, ovf = 0;
  - in_ready = 1 after reset.
- Latency: an operand accepted at edge n appears with out_valid = 1 after edge n+STAGES, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready and out_valid only. It never depends on in_valid.
- Simultaneous accept and drain: when out_valid && out_ready, a new operand is accepted in the same cycle and the pipeline advances.
- Stall onset: out_valid=1 && out_ready=0:
  - in_ready drops in the same cycle;
  - sum, c_out and ovf stay stable until the transfer.
- Reset mid-operation: all in-flight operations are discarded. out_valid = 0 immediately on rst_n low. No partial result is ever emitted.
- STAGES = 1 (CHUNK = WIDTH): a single registered adder with latency 1.

## Structure
- Shared package: no typedefs required. Holds the elaboration check helper for WIDTH % CHUNK.
- Sub-module add_chunk: combinational CHUNK-bit ripple slice.
  - Inputs: a, b, c_in. Outputs: sum, c_out.
  - Built from the existing structural full-adder cell.
  - Instantiated STAGES times with a generate loop.
- Top level: generate loop for the stage registers, skew/deskew arrays, valid chain and stall logic.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (latency 4) unless stated otherwise.

- Add: a=0x00FF, b=0x0001, c_in=0, sub=0 → 4 cycles later out_valid=1, sum=0x0100, c_out=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0.
- Subtract, sub=1, c_in=1:
  - a=0x0005, b=0x0007 → sum=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, b=0x0001 → sum=0x7FFF, c_out=1, ovf=1.
- Back-pressure: 8 back-to-back random operations, with out_ready held low for 3 cycles mid-stream.
  - in_ready is low exactly during the stall.
  - All 8 results match the reference model, in order, with none lost or duplicated.
  - Outputs are stable throughout the stall.
- Reset mid-flight: 3 operations in flight, then rst_n pulsed low → out_valid=0 and sum=0 at once. After release, none of the 3 results appear, and a new operation completes with latency 4.
- Parameter sweep: WIDTH=8, CHUNK=8 → latency 1, 0x7F+0x01 gives sum=0x80, ovf=1. WIDTH=32, CHUNK=4 → latency 8, random self-check over 1000 operations.

Source files
------------

// File: rtl/add_sub_pipe_pkg.sv
// add_sub_pipe_pkg
// Shared definitions for the pipelined adder/subtractor.
// Holds the elaboration-time check that the operand width splits evenly
// into per-stage slices. No ports.
package add_sub_pipe_pkg;

    // True when WIDTH can be cut into a whole number of CHUNK-bit slices.
    function automatic bit chunk_fits(int width, int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/add_sub_pipe_add_chunk.sv
// full_adder / add_chunk
// full_adder : single-bit structural full-adder cell.
// add_chunk  : combinational CHUNK-bit ripple slice built from full_adder.
// Ports (add_chunk):
//   a, b   in  CHUNK  slice operands
//   c_in   in  1      carry into the slice LSB
//   sum    out CHUNK  slice sum
//   c_out  out 1      carry out of the slice MSB
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    logic w_p;

    assign w_p   = a ^ b;
    assign sum   = w_p ^ c_in;
    assign c_out = (a & b) | (w_p & c_in);
endmodule

module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (w_c[i]),
            .sum   (sum[i]),
            .c_out (w_c[i+1])
        );
    end

    assign c_out = w_c[CHUNK];
endmodule

// File: rtl/add_sub_pipe.sv
// add_sub_pipe
// Pipelined ripple-carry adder/subtractor. The operands are cut into
// CHUNK-bit slices; stage k resolves slice k with the carry registered by
// stage k-1, so the critical path is one CHUNK-bit carry chain. Latency is
// STAGES = WIDTH/CHUNK cycles, throughput one result per cycle.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (a, b, c_in, sub)
//   out_valid / out_ready result handshake (sum, c_out, ovf)
//   c_out                carry out of MSB (subtract: 1 = no borrow)
//   ovf                  two's-complement signed overflow
module add_sub_pipe
    import add_sub_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_param_check
        $error("add_sub_pipe: WIDTH (%0d) must be a nonzero multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;

    // Whole-pipeline stall: only a held result blocks progress.
    assign w_advance = !(out_valid && !out_ready);
    assign in_ready  = w_advance;
    assign w_b_eff   = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO      = k * CHUNK;       // bits already resolved upstream
        localparam int REM     = WIDTH - LO;      // operand bits still to resolve
        localparam bit IS_LAST = (k == STAGES - 1);

        logic [REM-1:0]      w_a_in;
        logic [REM-1:0]      w_b_in;
        logic                w_c_in;
        logic                w_v_in;
        logic [CHUNK-1:0]    w_slice;
        logic                w_slice_c;
        logic [LO+CHUNK-1:0] w_sum_next;
        logic                w_load;

        logic                r_valid;
        logic                r_carry;
        logic [LO+CHUNK-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_a_in     = a;
            assign w_b_in     = w_b_eff;
            assign w_c_in     = c_in;
            assign w_v_in     = in_valid;
            assign w_sum_next = w_slice;
        end else begin : g_src
            assign w_a_in     = g_stage[k-1].g_skew.r_a_hi;
            assign w_b_in     = g_stage[k-1].g_skew.r_b_hi;
            assign w_c_in     = g_stage[k-1].r_carry;
            assign w_v_in     = g_stage[k-1].r_valid;
            assign w_sum_next = {w_slice, g_stage[k-1].r_sum};
        end

        add_chunk #(
            .CHUNK (CHUNK)
        ) u_add_chunk (
            .a     (w_a_in[CHUNK-1:0]),
            .b     (w_b_in[CHUNK-1:0]),
            .c_in  (w_c_in),
            .sum   (w_slice),
            .c_out (w_slice_c)
        );

        // The output stage only captures real results so that sum/c_out/ovf
        // keep their last value across bubbles.
        assign w_load = IS_LAST ? (w_advance && w_v_in) : w_advance;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
            end else if (w_advance) begin
                r_valid <= w_v_in;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum   <= '0;
                r_carry <= 1'b0;
            end else if (w_load) begin
                r_sum   <= w_sum_next;
                r_carry <= w_slice_c;
            end
        end

        if (IS_LAST) begin : g_last
            // The top slice still carries the operand MSBs, so overflow is
            // resolved here alongside the final sum slice.
            logic r_ovf;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_load) begin
                    r_ovf <= (w_a_in[REM-1] == w_b_in[REM-1]) &&
                             (w_slice[CHUNK-1] != w_a_in[REM-1]);
                end
            end
        end else begin : g_skew
            // Upper operand slices not yet consumed travel with the carry.
            logic [REM-CHUNK-1:0] r_a_hi;
            logic [REM-CHUNK-1:0] r_b_hi;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_advance) begin
                    r_a_hi <= w_a_in[REM-1:CHUNK];
                    r_b_hi <= w_b_in[REM-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign c_out     = g_stage[STAGES-1].r_carry;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
